// File: rtl/cmp_pkg.sv
// Shared state/result encodings and slice-result helpers for chunked_comparator.
package cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RES_EQ = 2'd0,
      RES_GT = 2'd1,
      RES_LT = 2'd2
   } res_t;

   function automatic res_t slice_res(input logic s_eq, input logic s_gt);
      res_t r;
      if (s_eq)      r = RES_EQ;
      else if (s_gt) r = RES_GT;
      else           r = RES_LT;
      return r;
   endfunction

   // One-hot {eq, gt, lt} view of a result code.
   function automatic logic [2:0] res_flags(input res_t r);
      logic [2:0] f;
      case (r)
         RES_EQ:  f = 3'b100;
         RES_GT:  f = 3'b010;
         RES_LT:  f = 3'b001;
         default: f = 3'b000;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned CHUNK-bit compare of one operand slice.
module cmp_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] sa,
   input  logic [CHUNK-1:0] sb,
   output logic             s_eq,
   output logic             s_gt
);

   assign s_eq = (sa == sb);
   assign s_gt = (sa > sb);

endmodule

// File: rtl/chunked_comparator.sv
// Sequential wide eq/gt/lt comparator, CHUNK bits per cycle MSB first; CMP_SIGNED_EN adds is_signed.
// Latency: 1..NCHUNK cycles accept-to-out_valid (NCHUNK when EARLY_EXIT=0).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module chunked_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int CHUNK      = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
   input  logic             is_signed,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             gt,
   output logic             lt,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             sgn_q, sgn_d;
   logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
   logic             dec_q, dec_d;
   res_t             dec_res_q, dec_res_d;

   logic             sgn_in;
   logic [CHUNK-1:0] sl_a, sl_b;
   logic             s_eq, s_gt;
   res_t             slice_r, fin_res;
   logic             last;

`ifdef CMP_SIGNED_EN
   assign sgn_in = is_signed;
`else
   assign sgn_in = 1'b0;
`endif

   // Flipping the sign bit of the top slice maps two's complement onto unsigned order.
   always_comb begin
      sl_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
      sl_b = b_q[int'(idx_q)*CHUNK +: CHUNK];
      if (sgn_q && (idx_q == IDX_TOP)) begin
         sl_a[CHUNK-1] = ~sl_a[CHUNK-1];
         sl_b[CHUNK-1] = ~sl_b[CHUNK-1];
      end
   end

   cmp_slice #(.CHUNK(CHUNK)) u_slice (
      .sa   (sl_a),
      .sb   (sl_b),
      .s_eq (s_eq),
      .s_gt (s_gt)
   );

   assign slice_r = slice_res(s_eq, s_gt);
   assign last    = (idx_q == '0);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sgn_d     = sgn_q;
      idx_d     = idx_q;
      eq_d      = eq_q;
      gt_d      = gt_q;
      lt_d      = lt_q;
      dec_d     = dec_q;
      dec_res_d = dec_res_q;
      fin_res   = slice_r;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d       = a;
               b_d       = b;
               sgn_d     = sgn_in;
               idx_d     = IDX_TOP;
               eq_d      = 1'b0;
               gt_d      = 1'b0;
               lt_d      = 1'b0;
               dec_d     = 1'b0;
               dec_res_d = RES_EQ;
               state_d   = ST_CMP;
            end
         end
         ST_CMP: begin
            if (EARLY_EXIT != 0) begin
               if ((slice_r != RES_EQ) || last) begin
                  {eq_d, gt_d, lt_d} = res_flags(slice_r);
                  state_d            = ST_DONE;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end else begin
               // The first differing slice decides; lower slices only burn cycles.
               if (dec_q) begin
                  fin_res = dec_res_q;
               end else if (slice_r != RES_EQ) begin
                  dec_d     = 1'b1;
                  dec_res_d = slice_r;
               end
               if (last) begin
                  {eq_d, gt_d, lt_d} = res_flags(fin_res);
                  state_d            = ST_DONE;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sgn_q     <= 1'b0;
         idx_q     <= '0;
         eq_q      <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
         dec_q     <= 1'b0;
         dec_res_q <= RES_EQ;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sgn_q     <= sgn_d;
         idx_q     <= idx_d;
         eq_q      <= eq_d;
         gt_q      <= gt_d;
         lt_q      <= lt_d;
         dec_q     <= dec_d;
         dec_res_q <= dec_res_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_CMP) || (state_q == ST_DONE);
   assign eq        = eq_q;
   assign gt        = gt_q;
   assign lt        = lt_q;

endmodule

// File: tb/tb_chunked_comparator.sv
// Bench: three comparator configs (32/8 early-exit, 32/8 full-scan, 8/8) checked against an arithmetic model.
module tb_chunked_comparator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  iv, ordy, sg;
   logic [2:0]  ir, ov, eqo, gto, lto, bsy;
   logic [31:0] av [3];
   logic [31:0] bv [3];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   chunked_comparator #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_ee1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
`ifdef CMP_SIGNED_EN
      .is_signed(sg[0]),
`endif
      .out_valid(ov[0]), .out_ready(ordy[0]), .eq(eqo[0]), .gt(gto[0]), .lt(lto[0]), .busy(bsy[0]));

   chunked_comparator #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_ee0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
`ifdef CMP_SIGNED_EN
      .is_signed(sg[1]),
`endif
      .out_valid(ov[1]), .out_ready(ordy[1]), .eq(eqo[1]), .gt(gto[1]), .lt(lto[1]), .busy(bsy[1]));

   chunked_comparator #(.WIDTH(8), .CHUNK(8), .EARLY_EXIT(1)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2][7:0]), .b(bv[2][7:0]),
`ifdef CMP_SIGNED_EN
      .is_signed(sg[2]),
`endif
      .out_valid(ov[2]), .out_ready(ordy[2]), .eq(eqo[2]), .gt(gto[2]), .lt(lto[2]), .busy(bsy[2]));

   function automatic int w_of(input int s);
      return (s == 2) ? 8 : 32;
   endfunction

   function automatic int ee_of(input int s);
      return (s == 1) ? 0 : 1;
   endfunction

   // Expected {eq,gt,lt} from integer values of the low w bits.
   function automatic logic [2:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input int w);
      longint m, xv, yv;
      m  = (longint'(1) << w) - 1;
      xv = longint'(x) & m;
      yv = longint'(y) & m;
      if (s && xv[w-1]) xv = xv - (longint'(1) << w);
      if (s && yv[w-1]) yv = yv - (longint'(1) << w);
      if (xv == yv) return 3'b100;
      if (xv > yv)  return 3'b010;
      return 3'b001;
   endfunction

   // Slices examined: down to the one holding the highest differing bit, or all of them.
   function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y, input int w, input int ee);
      logic [31:0] d;
      int n;
      int hb;
      n  = w / 8;
      d  = (x ^ y) & ((w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1));
      hb = -1;
      for (int i = 0; i < w; i++) if (d[i]) hb = i;
      if (ee == 0 || hb < 0) return n;
      return n - hb / 8;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int s, input logic [31:0] x, input logic [31:0] y, input logic sgv);
      int c = 0;
      while (!ir[s] && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      chk("in_ready_before_send", 32'(ir[s]), 32'd1);
      av[s] = x; bv[s] = y; sg[s] = sgv; iv[s] = 1'b1;
      @(posedge clk); #1;
      iv[s] = 1'b0;
      av[s] = $urandom; bv[s] = $urandom;
      sg[s] = 1'b0;
   endtask

   task automatic collect(input int s, input logic [2:0] er, input int ek, input string tag);
      int c = 0;
      chk({tag, "_busy_cmp"}, 32'(bsy[s]), 32'd1);
      chk({tag, "_res_cmp"}, 32'({eqo[s], gto[s], lto[s]}), 32'd0);
      while (!ov[s] && c < 64) begin
         @(posedge clk); #1;
         c++;
      end
      chk({tag, "_latency"}, 32'(c), 32'(ek));
      chk({tag, "_result"}, 32'({eqo[s], gto[s], lto[s]}), 32'(er));
   endtask

   task automatic handshake(input int s, input logic [2:0] er, input string tag);
      ordy[s] = 1'b1;
      @(posedge clk); #1;
      ordy[s] = 1'b0;
      chk({tag, "_in_ready_after"}, 32'({ir[s], ov[s], bsy[s]}), 32'b100);
      chk({tag, "_held"}, 32'({eqo[s], gto[s], lto[s]}), 32'(er));
   endtask

   task automatic run(input int s, input logic [31:0] x, input logic [31:0] y,
                      input logic sgv, input string tag);
      logic [2:0] er;
      int ek;
      er = ref_res(x, y, sgv, w_of(s));
      ek = ref_lat(x, y, w_of(s), ee_of(s));
      send(s, x, y, sgv);
      collect(s, er, ek, tag);
      handshake(s, er, tag);
   endtask

   initial begin
      logic [31:0] x, y;
      logic        sgv;
      int          s;
      iv = '0; ordy = '0; sg = '0;
      for (int i = 0; i < 3; i++) begin av[i] = '0; bv[i] = '0; end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_state", 32'({ir[i], ov[i], eqo[i], gto[i], lto[i], bsy[i]}), 32'b100000);
      end
      rst_n = 1'b1;

      run(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "eq_full");
      run(0, 32'h80000000, 32'h7FFFFFFF, 1'b0, "gt_early");
      run(1, 32'h80000000, 32'h7FFFFFFF, 1'b0, "gt_fullscan");
      run(0, 32'h12345600, 32'h12345601, 1'b0, "lt_lsb");
      run(1, 32'h12345600, 32'h12345601, 1'b0, "lt_lsb_fullscan");
      run(2, 32'h05, 32'h05, 1'b0, "w8_eq");
`ifdef CMP_SIGNED_EN
      run(0, 32'hFFFFFFFF, 32'h00000001, 1'b1, "signed_lt");
      run(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, "unsigned_gt");
      run(1, 32'hFFFFFFFF, 32'h00000001, 1'b1, "signed_lt_fullscan");
`endif

      // Backpressure: result held while new operands wait.
      send(0, 32'hA0000000, 32'hB0000000, 1'b0);
      collect(0, 3'b001, 1, "bp_first");
      av[0] = 32'h00000005; bv[0] = 32'h00000005; iv[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_flags", 32'({ir[0], ov[0]}), 32'b01);
         chk("bp_hold_res", 32'({eqo[0], gto[0], lto[0]}), 32'b001);
      end
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      chk("bp_idle_ready", 32'({ir[0], ov[0]}), 32'b10);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      av[0] = 32'hFFFF0000;
      collect(0, 3'b100, 4, "bp_second");
      handshake(0, 3'b100, "bp_second");

      // Reset during the second CMP cycle aborts the compare.
      send(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_state", 32'({ir[0], ov[0], eqo[0], gto[0], lto[0], bsy[0]}), 32'b100000);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("abort_no_stale", 32'({ov[0], bsy[0]}), 32'b00);
      end

      for (int n = 0; n < 40; n++) begin
         s = $urandom_range(0, 2);
         x = $urandom;
         case ($urandom_range(0, 2))
            0:       y = x;
            1:       y = x ^ (32'd1 << $urandom_range(0, w_of(s) - 1));
            default: y = $urandom;
         endcase
`ifdef CMP_SIGNED_EN
         sgv = 1'($urandom_range(0, 1));
`else
         sgv = 1'b0;
`endif
         run(s, x, y, sgv, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chunked_comparator.md
Name: chunked_comparator

Overview:
Parametrised sequential magnitude/equality comparator for wide operands. It replaces the fixed 4-bit combinational equality check.
- Compares two WIDTH-bit operands CHUNK bits per clock, MSB slice first.
- Reports eq/gt/lt through valid/ready handshakes on both sides.
- Sits between operand producers and control logic where a full-width comparator would violate timing or area budgets.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK
CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK (≥1)
EARLY_EXIT, 1, 1 = finish at first differing slice; 0 = always scan all NCHUNK slices (constant latency)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands a/b presented
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
out_valid  output  1  result valid; high only in DONE
out_ready  input  1  consumer accepts result
eq  output  1  a == b
gt  output  1  a > b
lt  output  1  a < b
busy  output  1  high in CMP or DONE

Behaviour:
- Reset (rst_n low at clk edge): state←IDLE; out_valid, eq, gt, lt, busy←0; slice index and operand registers cleared. in_ready=1 from the first post-reset cycle. Reset overrides every other event, including mid-CMP and mid-DONE; no result of an aborted compare is ever presented.
- FSM IDLE → CMP → DONE → IDLE:
  - IDLE: in_ready=1. When in_valid&&in_ready: latch a, b; idx←NCHUNK-1; clear eq/gt/lt; go to CMP.
  - CMP: each cycle compare slice [idx*CHUNK +: CHUNK], unsigned.
    - EARLY_EXIT=1: first unequal slice sets gt or lt, then DONE.
    - EARLY_EXIT=0: first unequal slice is recorded in a sticky decided flag; later slices are ignored and scanning continues.
    - At idx==0 go to DONE; if no slice differed, eq=1.
  - DONE: out_valid=1; eq/gt/lt held stable until out_valid&&out_ready, then IDLE. Results are held registered after the handshake until the next accept.
- Latency (accept edge to out_valid high): k cycles, where k = number of slices examined. EARLY_EXIT=1: k is 1..NCHUNK. EARLY_EXIT=0: k = NCHUNK.
- Throughput: one compare per k+2 cycles at best. There is no accept in the same cycle as the output handshake, because in_ready is 0 in DONE.
- Exactly one of eq/gt/lt is high whenever out_valid=1; all three are 0 during CMP.
- Inputs a/b may change freely after acceptance; only latched copies are used.
- NCHUNK=1: single CMP cycle, latency 1.
- idx counter width is $clog2(NCHUNK), minimum 1 bit; it never wraps below 0.

Optional Feature:
CMP_SIGNED_EN
- Defined: adds input port is_signed (1 bit), latched on accept. When the latched bit is 1, operands are compared as two's complement: in the MSB slice, the slice MSB is inverted on both sides before comparing. Other slices are unchanged.
- Undefined: no is_signed port; all compares are unsigned.

Decomposition:
- Shared package cmp_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_CMP=2'd1, ST_DONE=2'd2
  - result encoding: RES_EQ, RES_GT, RES_LT
- One natural sub-module: cmp_slice, a combinational CHUNK-bit comparator with outputs s_eq and s_gt, instantiated once and fed by the idx-selected slice.

Test Plan (WIDTH=32, CHUNK=8 unless noted):
1. a=b=32'hDEADBEEF, out_ready=1 → out_valid 4 cycles after accept, eq=1, gt=lt=0; in_ready returns 1 the cycle after the handshake.
2. a=32'h80000000, b=32'h7FFFFFFF, EARLY_EXIT=1 → gt=1 after 1 cycle. Repeat with EARLY_EXIT=0 → gt=1 after 4 cycles.
3. a=32'h12345600, b=32'h12345601 → lt=1 after 4 cycles (difference only in the LSB slice).
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → results stable, in_ready=0, new operands not accepted. out_ready=1 → IDLE, then the new operands are accepted.
5. Drive rst_n=0 for one edge during the 2nd CMP cycle → next cycle: state IDLE, out_valid=eq=gt=lt=busy=0, in_ready=1; no stale out_valid afterwards.
6. With CMP_SIGNED_EN, a=32'hFFFFFFFF, b=32'h00000001 → is_signed=1 gives lt=1; is_signed=0 gives gt=1. Also run WIDTH=8, CHUNK=8: a=8'h05, b=8'h05 → eq=1 after 1 cycle.
